siso_shift_register: RTL and testbench

- Parameterised serial-in/serial-out shift register.
- Delays a 1-bit serial stream by exactly DEPTH clock cycles.
- Used as a fixed bit-delay line and as a serial pipeline stage.
- Provides a parallel debug tap and fill-status outputs so downstream logic can tell when `serial_out` carries real data rather than reset fill.

---
 rtl/siso_shift_register.sv | 82 ++++++++
 tb/tb_siso_shift_register.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/siso_shift_register.sv
// -----------------------------------------------------------------------------
// siso_shift_register
//
// Serial-in / serial-out shift register that delays a 1-bit stream by exactly
// DEPTH clock cycles. It also exposes every stage as a parallel debug tap and
// tracks how many real bits have entered since reset. Downstream logic can
// therefore tell real data on serial_out apart from reset fill.
//
// Parameters
//   DEPTH      number of stages, which is also the latency in cycles (2..64)
//   RESET_VAL  value loaded into every stage while reset is asserted
//
// Ports
//   clk           system clock; all state changes on its rising edge
//   rst           synchronous, active-low reset (0 = reset)
//   serial_in     serial data bit, sampled on every non-reset rising edge
//   serial_out    oldest bit (stage DEPTH-1)
//   parallel_out  all stages; bit 0 is the newest sample
//   fill_count    bits shifted in since reset, saturating at DEPTH
//   out_valid     high once fill_count has reached DEPTH
//
// Every output is a register or a direct slice of one. There is no
// combinational path from serial_in to any output.
// -----------------------------------------------------------------------------
module siso_shift_register #(
  parameter int   DEPTH     = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_in,
  output logic                       serial_out,
  output logic [DEPTH-1:0]           parallel_out,
  output logic [$clog2(DEPTH+1)-1:0] fill_count,
  output logic                       out_valid
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;
  logic [CW-1:0]    fill_q;
  logic [CW-1:0]    fill_d;
  logic             valid_q;

  // Next-state shift network.
  // Stage 0 takes the new sample.
  // Every later stage takes the value of its predecessor.
  assign stage_d[0] = serial_in;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign stage_d[gi] = stage_q[gi-1];
    end
  endgenerate

  // fill_count saturates at DEPTH instead of wrapping.
  // Once the register is full it stays full until the next reset.
  assign fill_d = (fill_q == FULL) ? fill_q : fill_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      // Reset discards the serial_in value present on this edge.
      stage_q <= {DEPTH{RESET_VAL}};
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      // out_valid is registered from the next fill value.
      // This keeps it aligned with fill_count on the same edge.
      valid_q <= (fill_d == FULL);
    end
  end

  assign serial_out   = stage_q[DEPTH-1];
  assign parallel_out = stage_q;
  assign fill_count   = fill_q;
  assign out_valid    = valid_q;

endmodule

// File: tb/tb_siso_shift_register.sv
// -----------------------------------------------------------------------------
// tb_siso_shift_register
//
// Drives two instances with the same stimulus:
//   - DEPTH=4, RESET_VAL=0
//   - DEPTH=8, RESET_VAL=1
//
// The reference model keeps the list of bits accepted since the last reset.
// From that list it derives what each stage must hold after every edge.
// Each expectation is queued when an edge happens. A separate monitor pops
// the queue on the following falling edge and compares it with the outputs.
// -----------------------------------------------------------------------------
module tb_siso_shift_register;

  localparam int D_A = 4;
  localparam int D_B = 8;
  localparam int CWA = $clog2(D_A + 1);
  localparam int CWB = $clog2(D_B + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           sin = 1'b0;

  logic           so_a;
  logic [D_A-1:0] po_a;
  logic [CWA-1:0] fc_a;
  logic           ov_a;

  logic           so_b;
  logic [D_B-1:0] po_b;
  logic [CWB-1:0] fc_b;
  logic           ov_b;

  always #5 clk = ~clk;

  siso_shift_register #(.DEPTH(D_A), .RESET_VAL(1'b0)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (sin),
    .serial_out   (so_a),
    .parallel_out (po_a),
    .fill_count   (fc_a),
    .out_valid    (ov_a)
  );

  siso_shift_register #(.DEPTH(D_B), .RESET_VAL(1'b1)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (sin),
    .serial_out   (so_b),
    .parallel_out (po_b),
    .fill_count   (fc_b),
    .out_valid    (ov_b)
  );

  typedef struct {
    int          idx;
    logic [63:0] par_a;
    int          fill_a;
    logic        val_a;
    logic [63:0] par_b;
    int          fill_b;
    logic        val_b;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: bits accepted since reset (newest at the back)
  // and the number of non-reset edges since reset.
  bit hist[$];
  int edges_since_rst = 0;
  int txn = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected stage contents for a register of the given depth.
  // Stage i holds the bit accepted i edges ago, or the reset value if fewer
  // than i+1 bits have arrived since reset.
  function automatic logic [63:0] model_par(int depth, logic rv);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < depth; i++) begin
      if (i < hist.size()) p[i] = hist[hist.size()-1-i];
      else                 p[i] = rv;
    end
    return p;
  endfunction

  task automatic chk(string name, int id, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s txn=%0d actual=%0h required=%0h", name, id, act, exp);
    end
  endtask

  // One clock edge with the given reset level and serial_in value.
  // The model is updated at the edge and the expectation is queued.
  task automatic step(logic r, logic b);
    exp_t e;
    rst = r;
    sin = b;
    @(posedge clk);

    if (!r) begin
      hist.delete();
      edges_since_rst = 0;
    end else begin
      hist.push_back(b);
      if (hist.size() > 64) void'(hist.pop_front());
      if (edges_since_rst < 1000) edges_since_rst++;
    end

    e.idx    = txn++;
    e.par_a  = model_par(D_A, 1'b0);
    e.fill_a = (edges_since_rst < D_A) ? edges_since_rst : D_A;
    e.val_a  = (edges_since_rst >= D_A);
    e.par_b  = model_par(D_B, 1'b1);
    e.fill_b = (edges_since_rst < D_B) ? edges_since_rst : D_B;
    e.val_b  = (edges_since_rst >= D_B);
    exp_q.push_back(e);

    // Hold inputs briefly past the edge before the next change.
    #1;
  endtask

  // Monitor: compares the outputs against one queued expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_par",   e.idx, 64'(po_a), e.par_a);
        chk("a_sout",  e.idx, 64'(so_a), 64'(e.par_a[D_A-1]));
        chk("a_fill",  e.idx, 64'(fc_a), 64'(e.fill_a));
        chk("a_valid", e.idx, 64'(ov_a), 64'(e.val_a));
        chk("b_par",   e.idx, 64'(po_b), e.par_b);
        chk("b_sout",  e.idx, 64'(so_b), 64'(e.par_b[D_B-1]));
        chk("b_fill",  e.idx, 64'(fc_b), 64'(e.fill_b));
        chk("b_valid", e.idx, 64'(ov_b), 64'(e.val_b));
        $display("txn %0d: rst=%0b a_par=%b a_fill=%0d a_val=%0b b_par=%b b_fill=%0d b_val=%0b",
                 e.idx, rst, po_a, fc_a, ov_a, po_b, fc_b, ov_b);
      end
    end
  end

  // Stimulus.
  initial begin
    int pat[4];
    pat = '{1, 0, 1, 1};
    #1;

    // Reset held for two edges with serial_in=1.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Pattern 1,0,1,1 followed by zeros.
    // Ten shift edges in total, which also exercises saturation.
    for (int i = 0; i < 4; i++) step(1'b1, pat[i][0]);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);

    // Mid-stream reset after six edges of ones.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Walking one, long enough to pass through the 8-deep instance.
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);

    // Zero injected after a reset.
    // It must show on the RESET_VAL=1 instance exactly 8 edges later.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1);

    // Randomised stream with occasional resets.
    for (int i = 0; i < 150; i++) begin
      step(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)));
    end

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
